// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice: the 4-bit ALU op encoding,
// the highest legal op code, the response-buffer state type and a helper
// that flags illegal op codes.
package alu_arbiter_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    localparam logic [3:0] OP_MAX_LEGAL = 4'b1001;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return (op > OP_MAX_LEGAL);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// alu_arbiter_rr_pick2
// Two-input selector producing a one-hot grant.
//   valid[1:0] : request valids
//   last       : index of the requester granted last
//   mode       : 0 = round-robin, 1 = fixed priority (index 0 wins)
//   grant[1:0] : one-hot grant, 2'b00 when nothing is valid
module alu_arbiter_rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       mode,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            // Under contention round-robin hands the grant to whoever did not win last.
            if (mode || last) grant = 2'b01;
            else              grant = 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters (0 = core pipeline,
// 1 = auxiliary unit) and captures the result in a one-entry response buffer.
//   clk, rst                    : clock, synchronous active-high reset
//   prio_mode                   : 0 = round-robin, 1 = fixed priority
//   req_valid/req_ready[1:0]    : per-requester handshake
//   req_srca*/req_srcb*/req_op* : per-requester operands and op code
//   alu_srca/alu_srcb/alu_op    : operands driven to the external ALU
//   alu_result                  : combinational ALU result
//   resp_valid/resp_ready       : response handshake
//   resp_id/resp_result/resp_err: owner, captured result, illegal-op flag
//
// state     | meaning
// ----------+------------------------------------------------------------
// BUF_EMPTY | no response held; a request may be granted
// BUF_FULL  | response held; grant only if the consumer drains this cycle
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prio_mode,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_srca0,
    input  logic [DATA_W-1:0] req_srcb0,
    input  logic [DATA_W-1:0] req_srca1,
    input  logic [DATA_W-1:0] req_srcb1,
    input  logic [3:0]        req_op0,
    input  logic [3:0]        req_op1,
    output logic [DATA_W-1:0] alu_srca,
    output logic [DATA_W-1:0] alu_srcb,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_err
);

    buf_state_t state;
    logic       last_grant;
    logic [1:0] pick;
    logic       grant_ok;
    logic       xfer;

    alu_arbiter_rr_pick2 u_pick (
        .valid (req_valid),
        .last  (last_grant),
        .mode  (prio_mode),
        .grant (pick)
    );

    // Refill is allowed in the same cycle the held response drains.
    assign grant_ok  = !rst && ((state == BUF_EMPTY) || resp_ready);
    assign req_ready = grant_ok ? pick : 2'b00;
    assign xfer      = |req_ready;

    // Requester 0's fields are the idle default on the ALU inputs.
    always_comb begin
        alu_srca = req_srca0;
        alu_srcb = req_srcb0;
        alu_op   = req_op0;
        if (req_ready[1]) begin
            alu_srca = req_srca1;
            alu_srcb = req_srcb1;
            alu_op   = req_op1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BUF_EMPTY;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_err    <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (xfer) begin
                        state       <= BUF_FULL;
                        resp_valid  <= 1'b1;
                        resp_id     <= req_ready[1];
                        resp_result <= alu_result;
                        resp_err    <= op_illegal(alu_op);
                        last_grant  <= req_ready[1];
                    end
                end
                BUF_FULL: begin
                    if (xfer) begin
                        resp_valid  <= 1'b1;
                        resp_id     <= req_ready[1];
                        resp_result <= alu_result;
                        resp_err    <= op_illegal(alu_op);
                        last_grant  <= req_ready[1];
                    end else if (resp_ready) begin
                        state      <= BUF_EMPTY;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= BUF_EMPTY;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              prio_mode;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_srca0, req_srcb0, req_srca1, req_srcb1;
    logic [3:0]        req_op0, req_op1;
    logic [DATA_W-1:0] alu_srca, alu_srcb;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_id;
    logic [DATA_W-1:0] resp_result;
    logic              resp_err;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .prio_mode   (prio_mode),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_srca0   (req_srca0),
        .req_srcb0   (req_srcb0),
        .req_srca1   (req_srca1),
        .req_srcb1   (req_srcb1),
        .req_op0     (req_op0),
        .req_op1     (req_op1),
        .alu_srca    (alu_srca),
        .alu_srcb    (alu_srcb),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err)
    );

    function automatic logic [DATA_W-1:0] alu_ref(input logic [3:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:  return {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: return {{(DATA_W-1){1'b0}}, (a < b)};
            default: return '0;
        endcase
    endfunction

    // External shared ALU.
    always_comb alu_result = alu_ref(alu_op, alu_srca, alu_srcb);

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] result;
        logic              err;
    } resp_t;

    resp_t      sb[$];
    logic       m_last;
    logic [1:0] last_grant;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [3:0] op,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (idx == 0) begin
            req_op0 = op; req_srca0 = a; req_srcb0 = b;
        end else begin
            req_op1 = op; req_srca1 = a; req_srcb1 = b;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        logic [1:0] exp_ready;
        logic       allowed;
        resp_t      e;
        #1;
        allowed = !rst && ((sb.size() == 0) || resp_ready);
        exp_ready = 2'b00;
        if (allowed) begin
            if (req_valid == 2'b11)
                exp_ready = (prio_mode || m_last) ? 2'b01 : 2'b10;
            else
                exp_ready = req_valid;
        end
        check("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
        if (exp_ready == 2'b10) begin
            check("alu_op1", {28'd0, alu_op}, {28'd0, req_op1});
            check("alu_srca1", alu_srca, req_srca1);
        end else begin
            check("alu_op0", {28'd0, alu_op}, {28'd0, req_op0});
            check("alu_srca0", alu_srca, req_srca0);
        end
        check("resp_valid", {31'd0, resp_valid}, {31'd0, (sb.size() != 0)});
        if (sb.size() != 0) begin
            check("resp_id", {31'd0, resp_id}, {31'd0, sb[0].id});
            check("resp_result", resp_result, sb[0].result);
            check("resp_err", {31'd0, resp_err}, {31'd0, sb[0].err});
        end
        @(posedge clk);
        if (rst) begin
            sb.delete();
            m_last = 1'b1;
        end else begin
            if ((sb.size() != 0) && resp_ready) void'(sb.pop_front());
            if (exp_ready != 2'b00) begin
                e.id     = exp_ready[1];
                e.result = exp_ready[1] ? alu_ref(req_op1, req_srca1, req_srcb1)
                                        : alu_ref(req_op0, req_srca0, req_srcb0);
                e.err    = exp_ready[1] ? (req_op1 > 4'b1001) : (req_op0 > 4'b1001);
                sb.push_back(e);
                m_last = exp_ready[1];
            end
        end
        last_grant = exp_ready;
        @(negedge clk);
    endtask

    int g1_cnt;

    initial begin
        rst = 1'b1; prio_mode = 1'b0; req_valid = 2'b00; resp_ready = 1'b1;
        set_req(0, OP_ADD, '0, '0);
        set_req(1, OP_ADD, '0, '0);
        m_last = 1'b1;
        last_grant = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", {30'd0, req_ready}, 32'd0);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_id", {31'd0, resp_id}, 32'd0);
        check("rst_result", resp_result, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 0: ADD 5,3.
        set_req(0, OP_ADD, 32'd5, 32'd3);
        req_valid = 2'b01;
        step();
        check("add_grant", {30'd0, last_grant}, 32'd1);
        req_valid = 2'b00;
        #1;
        check("add_result", resp_result, 32'd8);
        check("add_id", {31'd0, resp_id}, 32'd0);
        step();

        // Round-robin contention with continuous drain.
        set_req(0, OP_SUB, 32'd10, 32'd4);
        set_req(1, OP_XOR, 32'hF0, 32'h0F);
        req_valid = 2'b11;
        step();
        check("rr_first", {30'd0, last_grant}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            logic [1:0] prev;
            prev = last_grant;
            step();
            check("rr_alt", {30'd0, last_grant}, {30'd0, ~prev});
        end
        req_valid = 2'b00;
        step();

        // Back-pressure: SLL 1,4 held while the consumer stalls.
        set_req(0, OP_SLL, 32'd1, 32'd4);
        req_valid = 2'b01;
        step();
        resp_ready = 1'b0;
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_result", resp_result, 32'd16);
            check("stall_grant", {30'd0, last_grant}, 32'd0);
        end
        resp_ready = 1'b1;
        step();
        check("drain_refill", {30'd0, last_grant}, 32'd2);
        req_valid = 2'b00;
        step();

        // Illegal op from requester 1.
        set_req(1, 4'b1111, 32'd7, 32'd7);
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        #1;
        check("ill_err", {31'd0, resp_err}, 32'd1);
        check("ill_result", resp_result, 32'd0);
        check("ill_id", {31'd0, resp_id}, 32'd1);
        step();

        // Fixed priority, then back to round-robin.
        set_req(0, OP_AND, 32'hFF00, 32'h0FF0);
        set_req(1, OP_OR, 32'h1, 32'h2);
        prio_mode = 1'b1;
        req_valid = 2'b11;
        g1_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (last_grant[1]) g1_cnt++;
        end
        check("prio_req1_grants", g1_cnt, 32'd0);
        prio_mode = 1'b0;
        step();
        check("rr_after_prio", {30'd0, last_grant}, 32'd2);
        req_valid = 2'b00;
        step();

        // Reset while a response is buffered.
        set_req(0, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        req_valid = 2'b01;
        step();
        resp_ready = 1'b0;
        req_valid = 2'b00;
        #1;
        check("slt_result", resp_result, 32'd1);
        rst = 1'b1;
        req_valid = 2'b11;
        step();
        check("rst_full_valid", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        resp_ready = 1'b1;
        step();
        check("post_rst_winner", {30'd0, last_grant}, 32'd1);
        req_valid = 2'b00;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
